// File: rtl/logic_unit_arbiter.sv
// Round-robin sequencer sharing one two-input gate unit among NREQ requesters.
// Grants one requester, drives the unit operands, and returns a registered, id-tagged result.
module logic_unit_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   a_in,
   input  logic [NREQ-1:0]   b_in,
   input  logic [3*NREQ-1:0] op_in,
   output logic [NREQ-1:0]   gnt,
   output logic              lu_a,
   output logic              lu_b,
   input  logic [6:0]        lu_o,
   output logic              res_valid,
   output logic [IDW-1:0]    res_id,
   output logic              res_out,
   output logic              res_err,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      EVAL,
      DONE
   } state_t;

   localparam int unsigned       NREQ_U   = NREQ;
   localparam logic [IDW-1:0]    LAST_IDX = IDW'(NREQ - 1);

   state_t         state, state_nxt;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] sel;
   logic [IDW-1:0] id_q;
   logic [2:0]     op_q;
   logic           do_grant;
   logic           do_result;
   logic           dec_out;
   logic           dec_err;

   // First asserted request at or after ptr, wrapping past NREQ-1.
   always_comb begin
      logic found;
      sel   = '0;
      found = 1'b0;
      for (int unsigned k = 0; k < NREQ_U; k++) begin
         int unsigned idx;
         idx = 32'(ptr) + k;
         if (idx >= NREQ_U) idx = idx - NREQ_U;
         if (!found && req[idx]) begin
            found = 1'b1;
            sel   = IDW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      do_grant  = 1'b0;
      do_result = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               do_grant  = 1'b1;
               state_nxt = EVAL;
            end
         end
         EVAL: begin
            do_result = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            if (|req) begin
               do_grant  = 1'b1;
               state_nxt = EVAL;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      dec_out = 1'b0;
      dec_err = 1'b0;
      case (op_q)
         3'd0:    dec_out = lu_o[0];
         3'd1:    dec_out = lu_o[1];
         3'd2:    dec_out = lu_o[2];
         3'd3:    dec_out = lu_o[3];
         3'd4:    dec_out = lu_o[4];
         3'd5:    dec_out = lu_o[5];
         3'd6:    dec_out = lu_o[6];
         default: dec_err = 1'b1;
      endcase
   end

   // Operands/opcode/id are captured at the grant edge so later input changes cannot disturb the result.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         gnt       <= '0;
         lu_a      <= 1'b0;
         lu_b      <= 1'b0;
         op_q      <= '0;
         id_q      <= '0;
         res_valid <= 1'b0;
         res_id    <= '0;
         res_out   <= 1'b0;
         res_err   <= 1'b0;
      end else begin
         gnt       <= '0;
         res_valid <= 1'b0;
         if (do_grant) begin
            gnt  <= NREQ'(1) << sel;
            lu_a <= a_in[sel];
            lu_b <= b_in[sel];
            op_q <= op_in[3*sel +: 3];
            id_q <= sel;
            ptr  <= (sel == LAST_IDX) ? '0 : sel + IDW'(1);
         end
         if (do_result) begin
            res_valid <= 1'b1;
            res_id    <= id_q;
            res_out   <= dec_out;
            res_err   <= dec_err;
         end
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: stimulus queues expected grants/results,
// a negedge monitor pops and compares whenever gnt or res_valid is seen.
module tb_logic_unit_arbiter;

   typedef struct packed {
      logic [1:0] id;
      logic       out;
      logic       err;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [3:0]  a_in;
   logic [3:0]  b_in;
   logic [11:0] op_in;
   logic [3:0]  gnt;
   logic        lu_a;
   logic        lu_b;
   logic [6:0]  lu_o;
   logic        res_valid;
   logic [1:0]  res_id;
   logic        res_out;
   logic        res_err;
   logic        busy;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [3:0] gnt_q[$];
   res_t       res_q[$];

   logic_unit_arbiter #(.NREQ(4), .IDW(2)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in), .op_in(op_in),
      .gnt(gnt), .lu_a(lu_a), .lu_b(lu_b), .lu_o(lu_o), .res_valid(res_valid),
      .res_id(res_id), .res_out(res_out), .res_err(res_err), .busy(busy)
   );

   // Shared gate unit: {not_a,xnor,xor,nor,nand,or,and}
   assign lu_o = {~lu_a, ~(lu_a ^ lu_b), lu_a ^ lu_b, ~(lu_a | lu_b),
                  ~(lu_a & lu_b), lu_a | lu_b, lu_a & lu_b};

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic fail(input string name);
      total_cnt++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   function automatic logic tt(input logic [2:0] op, input logic a, input logic b);
      case (op)
         3'd0: return a & b;
         3'd1: return a | b;
         3'd2: return ~(a & b);
         3'd3: return ~(a | b);
         3'd4: return a ^ b;
         3'd5: return ~(a ^ b);
         3'd6: return ~a;
         default: return 1'b0;
      endcase
   endfunction

   // Monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (gnt != 4'b0000) begin
            if (gnt_q.size() == 0) fail("gnt_unexpected");
            else chk("gnt", 32'(gnt), 32'(gnt_q.pop_front()));
         end
         if (res_valid) begin
            if (res_q.size() == 0) fail("res_unexpected");
            else begin
               res_t e;
               e = res_q.pop_front();
               chk("res_id", 32'(res_id), 32'(e.id));
               chk("res_out", 32'(res_out), 32'(e.out));
               chk("res_err", 32'(res_err), 32'(e.err));
            end
         end
      end
   end

   task automatic wait_gnt(output int cyc);
      cyc = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         cyc++;
         if (gnt != 4'b0000) return;
      end
      fail("gnt_timeout");
   endtask

   task automatic single(input int unsigned idx, input logic a, input logic b, input logic [2:0] op);
      int   cyc;
      res_t e;
      @(negedge clk);
      req             = 4'b0000;
      req[idx]        = 1'b1;
      a_in[idx]       = a;
      b_in[idx]       = b;
      op_in[3*idx +: 3] = op;
      e.id  = 2'(idx);
      e.out = tt(op, a, b);
      e.err = (op == 3'd7);
      gnt_q.push_back(4'(1 << idx));
      res_q.push_back(e);
      wait_gnt(cyc);
      req = 4'b0000;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_gnt"}, 32'(gnt), 0);
      chk({tag, "_lu_a"}, 32'(lu_a), 0);
      chk({tag, "_lu_b"}, 32'(lu_b), 0);
      chk({tag, "_res_valid"}, 32'(res_valid), 0);
      chk({tag, "_res_id"}, 32'(res_id), 0);
      chk({tag, "_res_out"}, 32'(res_out), 0);
      chk({tag, "_res_err"}, 32'(res_err), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
   endtask

   initial begin
      int   cyc;
      res_t e;
      rst   = 1'b1;
      req   = '0;
      a_in  = '0;
      b_in  = '0;
      op_in = '0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Reset during EVAL drops the in-flight result
      @(negedge clk);
      req = 4'b0001; a_in = 4'b0001; b_in = 4'b0001; op_in = '0;
      gnt_q.push_back(4'b0001);
      wait_gnt(cyc);
      req = 4'b0000;
      chk("busy_eval", 32'(busy), 1);
      #2 rst = 1'b1;
      #1 check_all_zero("midrst");
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      // ptr back to 0: lowest active request wins
      @(negedge clk);
      req = 4'b1001; a_in = 4'b1001; b_in = 4'b0000; op_in = {3'd6, 3'd3, 3'd3, 3'd1};
      gnt_q.push_back(4'b0001);
      e = '{id: 2'd0, out: 1'b1, err: 1'b0}; res_q.push_back(e);
      wait_gnt(cyc);
      req = 4'b0000;
      single(3, 1'b0, 1'b1, 3'd6);

      // Continuous requests: 0,1,2,3,0,1,2,3 one grant per 2 cycles
      @(negedge clk);
      a_in = 4'b1101; b_in = 4'b1001; op_in = {3'd2, 3'd4, 3'd1, 3'd0};
      for (int r = 0; r < 2; r++) begin
         gnt_q.push_back(4'b0001); e = '{id: 2'd0, out: 1'b1, err: 1'b0}; res_q.push_back(e);
         gnt_q.push_back(4'b0010); e = '{id: 2'd1, out: 1'b0, err: 1'b0}; res_q.push_back(e);
         gnt_q.push_back(4'b0100); e = '{id: 2'd2, out: 1'b1, err: 1'b0}; res_q.push_back(e);
         gnt_q.push_back(4'b1000); e = '{id: 2'd3, out: 1'b0, err: 1'b0}; res_q.push_back(e);
      end
      req = 4'b1111;
      for (int g = 0; g < 8; g++) begin
         wait_gnt(cyc);
         if (g > 0) chk("gnt_spacing", 32'(cyc), 2);
      end
      req = 4'b0000;

      // XOR on requester 0
      single(0, 1'b1, 1'b0, 3'd4);

      // Full truth-table sweep on requester 2, including reserved op 7
      for (int op = 0; op < 8; op++)
         for (int ab = 0; ab < 4; ab++)
            single(2, ab[1], ab[0], 3'(op));

      // Grant 1 -> ptr=2; req 0011 wraps to 0
      single(1, 1'b1, 1'b1, 3'd1);
      @(negedge clk);
      req = 4'b0011; a_in[0] = 1'b0; b_in[0] = 1'b0; op_in[2:0] = 3'd3;
      gnt_q.push_back(4'b0001); e = '{id: 2'd0, out: 1'b1, err: 1'b0}; res_q.push_back(e);
      wait_gnt(cyc);
      req = 4'b0000;

      // req[3] would win from ptr=3 but drops before the grant edge
      @(negedge clk);
      req = 4'b0100; a_in[2] = 1'b0; b_in[2] = 1'b0; op_in[8:6] = 3'd2;
      gnt_q.push_back(4'b0100); e = '{id: 2'd2, out: 1'b1, err: 1'b0}; res_q.push_back(e);
      wait_gnt(cyc);
      req = 4'b1001; a_in[0] = 1'b1; b_in[0] = 1'b0; op_in[2:0] = 3'd5;
      gnt_q.push_back(4'b0001); e = '{id: 2'd0, out: 1'b0, err: 1'b0}; res_q.push_back(e);
      @(negedge clk);
      req = 4'b0001;
      wait_gnt(cyc);
      req = 4'b0000;

      // Operand changes after the grant edge do not affect the result
      @(negedge clk);
      req = 4'b0001; a_in[0] = 1'b1; b_in[0] = 1'b1; op_in[2:0] = 3'd4;
      gnt_q.push_back(4'b0001); e = '{id: 2'd0, out: 1'b0, err: 1'b0}; res_q.push_back(e);
      wait_gnt(cyc);
      req = 4'b0000; a_in[0] = 1'b0; op_in[2:0] = 3'd5;
      repeat (4) @(negedge clk);
      chk("lu_a_hold", 32'(lu_a), 1);
      chk("lu_b_hold", 32'(lu_b), 1);
      chk("res_out_hold", 32'(res_out), 0);
      chk("busy_idle", 32'(busy), 0);

      for (int i = 0; i < 50 && (gnt_q.size() != 0 || res_q.size() != 0); i++)
         @(negedge clk);
      chk("gnt_q_left", 32'(gnt_q.size()), 0);
      chk("res_q_left", 32'(res_q.size()), 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
